pipe_ctrl_unit: RTL and testbench

//  Pipelined main controller for the five-stage MIPS core. Decodes the ID-stage opcode,

---
 rtl/pipe_ctrl_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main controller: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall, branch flush and EX forwarding selects.
module pipe_ctrl_unit #(
  parameter int OPCODE_W  = 6,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                flush,
  output logic                stall,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                id_illegal,
  output logic                ex_alu_src,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_dest,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_branch,
  output logic                mem_branch_ne,
  output logic [REG_W-1:0]    mem_dest,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [REG_W-1:0]    wb_dest,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               branch_ne;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   dest;
  } id_ex_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             branch_ne;
    logic [REG_W-1:0] dest;
  } ex_mem_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] dest;
  } mem_wb_t;

  id_ex_t  id_ex, id_nxt;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic       is_r, is_lw, is_sw, is_beq, is_bne, is_ori, is_addi;
  logic       known, reg_dst, uses_rt, bubble;
  logic [1:0] aop;
  logic [REG_W-1:0] dest;

  assign is_r    = (id_opcode == OP_R);
  assign is_lw   = (id_opcode == OP_LW);
  assign is_sw   = (id_opcode == OP_SW);
  assign is_beq  = (id_opcode == OP_BEQ);
  assign is_bne  = (id_opcode == OP_BNE);
  assign is_ori  = (id_opcode == OP_ORI);
  assign is_addi = (id_opcode == OP_ADDI);

  // main decoder: opcode -> control word for the ID/EX register
  always_comb begin
    id_nxt  = '0;
    known   = 1'b1;
    reg_dst = 1'b0;
    aop     = 2'b00;
    unique case (1'b1)
      is_r: begin
        reg_dst          = 1'b1;
        aop              = 2'b10;
        id_nxt.reg_write = 1'b1;
      end
      is_lw: begin
        id_nxt.alu_src    = 1'b1;
        id_nxt.reg_write  = 1'b1;
        id_nxt.mem_read   = 1'b1;
        id_nxt.mem_to_reg = 1'b1;
      end
      is_sw: begin
        id_nxt.alu_src   = 1'b1;
        id_nxt.mem_write = 1'b1;
      end
      is_beq: begin
        aop           = 2'b01;
        id_nxt.branch = 1'b1;
      end
      is_bne: begin
        aop              = 2'b01;
        id_nxt.branch_ne = 1'b1;
      end
      is_ori: begin
        aop              = 2'b11;
        id_nxt.alu_src   = 1'b1;
        id_nxt.reg_write = 1'b1;
      end
      is_addi: begin
        id_nxt.alu_src   = 1'b1;
        id_nxt.reg_write = 1'b1;
      end
      default: known = 1'b0;
    endcase
    dest          = reg_dst ? id_rd : id_rt;
    id_nxt.alu_op = ALUOP_W'(aop);
    id_nxt.rs     = id_rs;
    id_nxt.rt     = id_rt;
    id_nxt.dest   = dest;
    if (dest == '0) id_nxt.reg_write = 1'b0;
  end

  assign uses_rt    = is_r | is_sw | is_beq | is_bne;
  assign id_illegal = id_valid & ~known;

  // load-use detection against the load sitting in EX
  always_comb begin
    stall = 1'b0;
    if (HAZARD_EN) begin
      stall = id_valid & id_ex.mem_read & (id_ex.dest != '0) &
              ((id_ex.dest == id_rs) |
               ((id_ex.dest == id_rt) & uses_rt));
    end
  end

  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign bubble      = ~id_valid | ~known | stall | flush;

  // ID/EX register: bubble on stall, flush, empty or illegal slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      id_ex <= '0;
    else if (bubble) id_ex <= '0;
    else             id_ex <= id_nxt;
  end

  // EX/MEM register: killed by a taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem <= '0;
    end else if (flush) begin
      ex_mem <= '0;
    end else begin
      ex_mem.reg_write  <= id_ex.reg_write;
      ex_mem.mem_to_reg <= id_ex.mem_to_reg;
      ex_mem.mem_read   <= id_ex.mem_read;
      ex_mem.mem_write  <= id_ex.mem_write;
      ex_mem.branch     <= id_ex.branch;
      ex_mem.branch_ne  <= id_ex.branch_ne;
      ex_mem.dest       <= id_ex.dest;
    end
  end

  // MEM/WB register: the instruction in MEM always completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb <= '0;
    end else begin
      mem_wb.reg_write  <= ex_mem.reg_write;
      mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
      mem_wb.dest       <= ex_mem.dest;
    end
  end

  // forwarding selects, younger producer in EX/MEM wins
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      if (ex_mem.reg_write & (ex_mem.dest != '0) &
          (ex_mem.dest == id_ex.rs))
        fwd_a = 2'b10;
      else if (mem_wb.reg_write & (mem_wb.dest != '0) &
               (mem_wb.dest == id_ex.rs))
        fwd_a = 2'b01;
      if (ex_mem.reg_write & (ex_mem.dest != '0) &
          (ex_mem.dest == id_ex.rt))
        fwd_b = 2'b10;
      else if (mem_wb.reg_write & (mem_wb.dest != '0) &
               (mem_wb.dest == id_ex.rt))
        fwd_b = 2'b01;
    end
  end

  assign ex_alu_src    = id_ex.alu_src;
  assign ex_alu_op     = id_ex.alu_op;
  assign ex_rs         = id_ex.rs;
  assign ex_rt         = id_ex.rt;
  assign ex_dest       = id_ex.dest;
  assign mem_read      = ex_mem.mem_read;
  assign mem_write     = ex_mem.mem_write;
  assign mem_branch    = ex_mem.branch;
  assign mem_branch_ne = ex_mem.branch_ne;
  assign mem_dest      = ex_mem.dest;
  assign wb_reg_write  = mem_wb.reg_write;
  assign wb_mem_to_reg = mem_wb.mem_to_reg;
  assign wb_dest       = mem_wb.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: per-cycle vector table plus
// hand sequences for decode, flush, illegal opcode and async reset.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, flush;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;

  logic stall, pc_write, if_id_write, id_illegal;
  logic ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rs, ex_rt, ex_dest;
  logic mem_read, mem_write, mem_branch, mem_branch_ne;
  logic [4:0] mem_dest;
  logic wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_dest;
  logic [1:0] fwd_a, fwd_b;

  logic n_stall, n_pcw, n_ifw, n_ill, n_src;
  logic [1:0] n_aop;
  logic [4:0] n_rs, n_rt, n_edst;
  logic n_mrd, n_mwr, n_mbr, n_mbn;
  logic [4:0] n_mdst;
  logic n_wrw, n_wm2r;
  logic [4:0] n_wdst;
  logic [1:0] n_fa, n_fb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .stall(stall),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_illegal(id_illegal), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .mem_read(mem_read),
    .mem_write(mem_write), .mem_branch(mem_branch),
    .mem_branch_ne(mem_branch_ne), .mem_dest(mem_dest),
    .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  pipe_ctrl_unit #(.HAZARD_EN(1'b0), .FWD_EN(1'b0)) nod (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .stall(n_stall),
    .pc_write(n_pcw), .if_id_write(n_ifw),
    .id_illegal(n_ill), .ex_alu_src(n_src),
    .ex_alu_op(n_aop), .ex_rs(n_rs), .ex_rt(n_rt),
    .ex_dest(n_edst), .mem_read(n_mrd),
    .mem_write(n_mwr), .mem_branch(n_mbr),
    .mem_branch_ne(n_mbn), .mem_dest(n_mdst),
    .wb_reg_write(n_wrw), .wb_mem_to_reg(n_wm2r),
    .wb_dest(n_wdst), .fwd_a(n_fa), .fwd_b(n_fb)
  );

  typedef struct packed {
    logic       st;
    logic       ill;
    logic       src;
    logic [1:0] aop;
    logic [4:0] edst;
    logic       mrd;
    logic       mwr;
    logic       mbr;
    logic [4:0] mdst;
    logic       wrw;
    logic       wm2r;
    logic [4:0] wdst;
    logic [1:0] fa;
    logic [1:0] fb;
  } obs_t;

  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    obs_t       e;
  } vec_t;

  vec_t tbl[$];

  function automatic obs_t mk(
    input logic st, ill, src, input logic [1:0] aop,
    input logic [4:0] edst, input logic mrd, mwr, mbr,
    input logic [4:0] mdst, input logic wrw, wm2r,
    input logic [4:0] wdst, input logic [1:0] fa, fb);
    obs_t o;
    o = '{st, ill, src, aop, edst, mrd, mwr, mbr,
          mdst, wrw, wm2r, wdst, fa, fb};
    return o;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o = '{stall, id_illegal, ex_alu_src, ex_alu_op,
          ex_dest, mem_read, mem_write, mem_branch,
          mem_dest, wb_reg_write, wb_mem_to_reg,
          wb_dest, fwd_a, fwd_b};
    return o;
  endfunction

  task automatic add(input logic v, input logic [5:0] op,
                     input logic [4:0] rs, rt, rd,
                     input obs_t e);
    vec_t t;
    t = '{v, op, rs, rt, rd, e};
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [4:0] rs, rt, rd,
                       input logic fl);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
    end
  endtask

  obs_t z;
  logic [6:0] dexp[7];
  logic [5:0] dops[7];

  initial begin
    z = '0;
    // lw rt=5 ... add rs=5 with repeated row while stalled
    add(1, R, 1, 2, 3, z);
    add(0, R, 0, 0, 0, mk(0,0,0,2,3,0,0,0,0,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,3,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1,0,3,0,0));
    add(1, R, 1, 2, 0, z);
    add(0, R, 0, 0, 0, mk(0,0,0,2,0,0,0,0,0,0,0,0,0,0));
    add(0, R, 0, 0, 0, z);
    add(0, R, 0, 0, 0, z);
    add(1, R, 1, 2, 4, z);
    add(1, R, 4, 4, 6, mk(0,0,0,2,4,0,0,0,0,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,2,6,0,0,0,4,0,0,0,2,2));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,6,1,0,4,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1,0,6,0,0));
    add(1, R, 1, 2, 4, z);
    add(0, R, 0, 0, 0, mk(0,0,0,2,4,0,0,0,0,0,0,0,0,0));
    add(1, R, 4, 4, 6, mk(0,0,0,0,0,0,0,0,4,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,2,6,0,0,0,0,1,0,4,1,1));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,6,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1,0,6,0,0));
    add(1, LW, 1, 5, 0, z);
    add(1, R, 5, 2, 7, mk(1,0,1,0,5,0,0,0,0,0,0,0,0,0));
    add(1, R, 5, 2, 7, mk(0,0,0,0,0,1,0,0,5,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,2,7,0,0,0,0,1,1,5,1,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,7,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1,0,7,0,0));
    add(1, LW, 1, 5, 0, z);
    add(1, ORI, 1, 5, 0, mk(0,0,1,0,5,0,0,0,0,0,0,0,0,0));
    add(0, R, 0, 0, 0, mk(0,0,1,3,5,1,0,0,5,0,0,0,0,2));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,5,1,1,5,0,0));
    add(0, R, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1,0,5,0,0));

    // {src, aop, mrd, mwr, br, bne} then wb {rw, m2r} checked apart
    dops[0] = R;   dexp[0] = 7'b0_10_0000;
    dops[1] = LW;  dexp[1] = 7'b1_00_1000;
    dops[2] = SW;  dexp[2] = 7'b1_00_0100;
    dops[3] = BEQ; dexp[3] = 7'b0_01_0010;
    dops[4] = BNE; dexp[4] = 7'b0_01_0001;
    dops[5] = ORI; dexp[5] = 7'b1_11_0000;
    dops[6] = ADI; dexp[6] = 7'b1_00_0000;

    rst_n = 1'b0;
    drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("rst_obs", snap(), z);
    chk("rst_pcw", {pc_write, if_id_write}, 2'b11);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt,
            tbl[i].rd, 1'b0);
      chk($sformatf("row%0d", i), snap(), tbl[i].e);
      chk($sformatf("row%0d_pcw", i), {pc_write, if_id_write},
          {2{~tbl[i].e.st}});
      chk($sformatf("row%0d_nod", i), {n_stall, n_fa, n_fb},
          5'd0);
      tick();
    end

    for (int d = 0; d < 7; d++) begin
      drive(1'b1, dops[d], 5'd1, 5'd2, 5'd3, 1'b0);
      chk($sformatf("dec%0d_ill", d), id_illegal, 1'b0);
      tick();
      drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
      chk($sformatf("dec%0d_ex", d),
          {ex_alu_src, ex_alu_op, ex_dest},
          {dexp[d][6:4], (d == 0) ? 5'd3 : 5'd2});
      tick();
      chk($sformatf("dec%0d_mem", d),
          {mem_read, mem_write, mem_branch, mem_branch_ne},
          dexp[d][3:0]);
      tick();
      chk($sformatf("dec%0d_wb", d),
          {wb_reg_write, wb_mem_to_reg},
          {d == 0 || d == 1 || d == 5 || d == 6, d == 1});
      tick();
    end

    drive(1'b1, BAD, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("ill_on", {id_illegal, stall}, 2'b10);
    drive(1'b0, BAD, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("ill_novalid", id_illegal, 1'b0);
    drive(1'b1, BAD, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
      chk($sformatf("ill_bub%0d", k),
          {ex_alu_src, ex_alu_op, mem_read, mem_write,
           mem_branch, mem_branch_ne, wb_reg_write}, 8'd0);
      tick();
    end

    drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, R, 5'd1, 5'd2, 5'd8, 1'b0);
    chk("fl_beq_ex", {ex_alu_op, ex_dest}, {2'b01, 5'd2});
    tick();
    drive(1'b1, LW, 5'd1, 5'd9, 5'd0, 1'b1);
    chk("fl_beq_mem", {mem_branch, ex_alu_op, ex_dest},
        {1'b1, 2'b10, 5'd8});
    tick();
    drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("fl_killed",
        {ex_alu_src, ex_alu_op, ex_dest, mem_read,
         mem_branch, mem_dest, wb_reg_write, wb_dest},
        {1'b0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd2});
    tick();
    idle(2);

    drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    drive(1'b1, R, 5'd5, 5'd2, 5'd7, 1'b1);
    chk("fs_stall", {stall, pc_write}, 2'b10);
    tick();
    drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("fs_bub", {stall, ex_alu_op, ex_dest, mem_read, mem_dest},
        14'd0);
    tick();
    chk("fs_nowb", {wb_reg_write, wb_mem_to_reg, wb_dest}, 7'd0);
    idle(2);

    drive(1'b1, R, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    drive(1'b1, R, 5'd5, 5'd2, 5'd7, 1'b0);
    chk("rs_pre", {stall, pc_write, ex_dest, mem_dest},
        {2'b10, 5'd5, 5'd3});
    rst_n = 1'b0;
    #1;
    chk("rs_async", snap(), z);
    chk("rs_async_pcw", {pc_write, if_id_write, ex_rs, ex_rt},
        {2'b11, 10'd0});
    tick();
    chk("rs_hold", snap(), z);
    rst_n = 1'b1;
    drive(1'b1, R, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("rs_first", {ex_alu_op, ex_dest, mem_dest, wb_reg_write},
        {2'b10, 5'd3, 5'd0, 1'b0});
    tick();
    chk("rs_mem", {mem_dest, wb_reg_write}, {5'd3, 1'b0});
    tick();
    chk("rs_wb", {wb_reg_write, wb_dest}, {1'b1, 5'd3});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
